sequence_generator: RTL and testbench

- Transmit side of the 3-bit sequence-detection link.
- On a start pulse, drives the fixed 8-symbol pattern 001, 101, 110, 000, 110, 110, 011, 101 onto a 3-bit bus, one or more times.
- Uses a valid/ready handshake and an optional idle gap between repetitions.
- Sits upstream of the sequence detector and serves as a stimulus source for it in system tests and bring-up.

---
 rtl/seq_pkg.sv | 24 ++
 rtl/seq_gap_counter.sv | 39 +++
 rtl/sequence_generator.sv | 140 ++++++++++++++
 tb/tb_sequence_generator.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared constants for the 3-bit sequence link: pattern table, idle symbol and FSM states.
// Both the generator and the detector import this package.
package seq_pkg;

   localparam int SEQ_LEN   = 8;
   localparam int SEQ_IDX_W = 3;

   localparam logic [2:0] SEQ_IDLE = 3'b111;

   localparam logic [2:0] SEQ_PATTERN [SEQ_LEN] = '{
      3'b001, 3'b101, 3'b110, 3'b000, 3'b110, 3'b110, 3'b011, 3'b101
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } seq_state_e;

   function automatic logic [2:0] seq_symbol(input logic [SEQ_IDX_W-1:0] idx);
      return SEQ_PATTERN[idx];
   endfunction

endpackage

// File: rtl/seq_gap_counter.sv
// Loadable down-counter with a zero flag; times the idle gap between pattern repetitions.
module seq_gap_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   input  logic         clear_i,
   output logic         zero_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Clear wins over load, load wins over decrement; the count saturates at zero.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/sequence_generator.sv
// Transmit side of the 3-bit sequence link: sends the 8-symbol pattern R times with a valid/ready handshake.
// Optional abort input is built in when SEQ_GEN_ABORT_EN is defined.
module sequence_generator
   import seq_pkg::*;
#(
   parameter int unsigned GAP_CYCLES = 0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic [3:0] repeat_count,
   input  logic       ready,
`ifdef SEQ_GEN_ABORT_EN
   input  logic       abort,
`endif
   output logic [2:0] data,
   output logic       data_valid,
   output logic       busy,
   output logic       done
);

   localparam logic [3:0]           GAP_LOAD = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
   localparam logic [SEQ_IDX_W-1:0] LAST_IDX = SEQ_IDX_W'(SEQ_LEN - 1);

   seq_state_e           state_q;
   logic [SEQ_IDX_W-1:0] sym_idx_q;
   logic [3:0]           rep_cnt_q;
   logic [2:0]           data_q;
   logic                 valid_q;
   logic                 busy_q;
   logic                 done_q;

   logic abort_w;
   logic accept;
   logic last_sym;
   logic gap_load;
   logic gap_dec;
   logic gap_zero;

`ifdef SEQ_GEN_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   // Handshake: a symbol moves only on a cycle where data_valid and ready are both high.
   assign accept   = valid_q && ready;
   assign last_sym = (sym_idx_q == LAST_IDX);
   assign gap_load = (state_q == SEND) && accept && last_sym && (rep_cnt_q != 4'd0) && (GAP_CYCLES != 0);
   assign gap_dec  = (state_q == GAP) && !gap_zero;

   seq_gap_counter #(.W(4)) u_gap_counter (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_i     (gap_load),
      .load_val_i (GAP_LOAD),
      .dec_i      (gap_dec),
      .clear_i    (abort_w),
      .zero_o     (gap_zero)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         sym_idx_q <= '0;
         rep_cnt_q <= 4'd0;
         data_q    <= SEQ_IDLE;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (abort_w) begin
            state_q   <= IDLE;
            sym_idx_q <= '0;
            rep_cnt_q <= 4'd0;
            data_q    <= SEQ_IDLE;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start) begin
                     state_q   <= SEND;
                     sym_idx_q <= '0;
                     rep_cnt_q <= (repeat_count == 4'd0) ? 4'd0 : repeat_count - 4'd1;
                     data_q    <= seq_symbol('0);
                     valid_q   <= 1'b1;
                     busy_q    <= 1'b1;
                  end
               end
               SEND: begin
                  if (accept) begin
                     if (!last_sym) begin
                        sym_idx_q <= sym_idx_q + 1'b1;
                        data_q    <= seq_symbol(sym_idx_q + 1'b1);
                     end else begin
                        sym_idx_q <= '0;
                        if (rep_cnt_q == 4'd0) begin
                           state_q <= IDLE;
                           data_q  <= SEQ_IDLE;
                           valid_q <= 1'b0;
                           busy_q  <= 1'b0;
                           done_q  <= 1'b1;
                        end else if (GAP_CYCLES == 0) begin
                           rep_cnt_q <= rep_cnt_q - 4'd1;
                           data_q    <= seq_symbol('0);
                        end else begin
                           state_q   <= GAP;
                           rep_cnt_q <= rep_cnt_q - 4'd1;
                           data_q    <= SEQ_IDLE;
                           valid_q   <= 1'b0;
                        end
                     end
                  end
               end
               GAP: begin
                  if (gap_zero) begin
                     state_q <= SEND;
                     data_q  <= seq_symbol('0);
                     valid_q <= 1'b1;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  data_q  <= SEQ_IDLE;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign data       = data_q;
   assign data_valid = valid_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Bench for sequence_generator: dut_a (GAP_CYCLES=2) scoreboarded, dut_b (GAP_CYCLES=0) for back-to-back.
// Build with SEQ_GEN_ABORT_EN defined to include the abort scenario.
module tb_sequence_generator;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start_a;
   logic       start_b;
   logic [3:0] repeat_count;
   logic       ready;
`ifdef SEQ_GEN_ABORT_EN
   logic       abort;
`endif

   logic [2:0] data_a, data_b;
   logic       valid_a, valid_b;
   logic       busy_a, busy_b;
   logic       done_a, done_b;

   int         n_checks = 0;
   int         n_pass   = 0;
   int         cyc      = 0;
   int         start_cyc = 0;
   int         done_cnt_a = 0;
   int         last_done_cyc = 0;
   bit         mon_en = 1'b0;
   logic [2:0] exp_q[$];
   logic [2:0] pat [8];

   sequence_generator #(.GAP_CYCLES(2)) dut_a (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start_a),
      .repeat_count (repeat_count),
      .ready        (ready),
`ifdef SEQ_GEN_ABORT_EN
      .abort        (abort),
`endif
      .data         (data_a),
      .data_valid   (valid_a),
      .busy         (busy_a),
      .done         (done_a)
   );

   sequence_generator #(.GAP_CYCLES(0)) dut_b (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start_b),
      .repeat_count (repeat_count),
      .ready        (ready),
`ifdef SEQ_GEN_ABORT_EN
      .abort        (abort),
`endif
      .data         (data_b),
      .data_valid   (valid_b),
      .busy         (busy_b),
      .done         (done_b)
   );

   // Clock / cycle counter / watchdog
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no summary, want finish");
      $fatal(1, "watchdog");
   end

   // Scoreboard monitor for dut_a: every accepted symbol is popped and compared.
   always @(negedge clk) begin
      logic [2:0] exp_sym;
      if (mon_en) begin
         if (done_a === 1'b1) begin
            done_cnt_a++;
            last_done_cyc = cyc;
         end
         if (valid_a === 1'b1 && ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL sb_extra: got data=%b, want no symbol (queue empty)", data_a);
            end else begin
               exp_sym = exp_q.pop_front();
               if (data_a !== exp_sym) $display("FAIL sb_data: got %b, want %b", data_a, exp_sym);
               else n_pass++;
            end
         end else if (valid_a !== 1'b1) begin
            n_checks++;
            if (data_a !== 3'b111 || valid_a !== 1'b0) $display("FAIL idle_data: got data=%b valid=%b, want 111/0", data_a, valid_a);
            else n_pass++;
         end
      end
   end

   // Driver tasks
   task automatic push_pattern(input int reps);
      for (int r = 0; r < reps; r++)
         for (int i = 0; i < 8; i++) exp_q.push_back(pat[i]);
   endtask

   // Called at #1 after a rising edge; returns at #1 after the edge that samples start.
   task automatic send_start(input logic [3:0] rc);
      repeat_count = rc;
      start_a = 1'b1;
      push_pattern((rc == 4'd0) ? 1 : int'(rc));
      @(posedge clk); #1;
      start_cyc = cyc;
      start_a = 1'b0;
   endtask

   task automatic wait_idle(input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (busy_a === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Scenarios
   task automatic test_reset;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (data_a !== 3'b111) $display("FAIL rst_data: got %b, want 111", data_a); else n_pass++;
      n_checks++; if (valid_a !== 1'b0) $display("FAIL rst_valid: got %b, want 0", valid_a); else n_pass++;
      n_checks++; if (busy_a !== 1'b0) $display("FAIL rst_busy: got %b, want 0", busy_a); else n_pass++;
      n_checks++; if (done_a !== 1'b0) $display("FAIL rst_done: got %b, want 0", done_a); else n_pass++;
      reset_n = 1'b1;
      mon_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) $display("FAIL rst_release: got busy=%b done=%b, want 0/0", busy_a, done_a); else n_pass++;
   endtask

   task automatic test_single;
      int d0 = done_cnt_a;
      send_start(4'd0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_checks++; if (valid_a !== 1'b1) $display("FAIL single_valid[%0d]: got %b, want 1", i, valid_a); else n_pass++;
      end
      @(negedge clk);
      n_checks++; if (done_a !== 1'b1 || busy_a !== 1'b0) $display("FAIL single_done: got done=%b busy=%b, want 1/0", done_a, busy_a); else n_pass++;
      @(negedge clk);
      n_checks++; if (done_a !== 1'b0 || data_a !== 3'b111) $display("FAIL single_after: got done=%b data=%b, want 0/111", done_a, data_a); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (last_done_cyc - start_cyc !== 8) $display("FAIL single_latency: got %0d, want 8", last_done_cyc - start_cyc); else n_pass++;
      n_checks++; if (done_cnt_a !== d0 + 1) $display("FAIL single_done_cnt: got %0d, want %0d", done_cnt_a - d0, 1); else n_pass++;
      n_checks++; if (exp_q.size() !== 0) $display("FAIL single_queue: got %0d left, want 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_gap;
      int d0 = done_cnt_a;
      int busy_n = 0;
      int gap_n = 0;
      send_start(4'd3);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (busy_a !== 1'b1) break;
         busy_n++;
         if (valid_a !== 1'b1) gap_n++;
      end
      n_checks++; if (busy_n !== 28) $display("FAIL gap_busy_cycles: got %0d, want 28", busy_n); else n_pass++;
      n_checks++; if (gap_n !== 4) $display("FAIL gap_idle_cycles: got %0d, want 4", gap_n); else n_pass++;
      n_checks++; if (done_a !== 1'b1) $display("FAIL gap_done: got %b, want 1", done_a); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (last_done_cyc - start_cyc !== 28) $display("FAIL gap_latency: got %0d, want 28", last_done_cyc - start_cyc); else n_pass++;
      n_checks++; if (done_cnt_a !== d0 + 1) $display("FAIL gap_done_cnt: got %0d, want 1", done_cnt_a - d0); else n_pass++;
      n_checks++; if (exp_q.size() !== 0) $display("FAIL gap_queue: got %0d left, want 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_stall;
      int d0 = done_cnt_a;
      bit ok;
      send_start(4'd0);
      repeat (3) @(posedge clk);
      #1 ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_checks++; if (data_a !== 3'b000 || valid_a !== 1'b1) $display("FAIL stall_hold[%0d]: got data=%b valid=%b, want 000/1", k, data_a, valid_a); else n_pass++;
         @(posedge clk);
      end
      #1 ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (data_a !== 3'b110) $display("FAIL stall_resume: got %b, want 110", data_a); else n_pass++;
      wait_idle(50, ok);
      n_checks++; if (!ok) $display("FAIL stall_timeout: got busy=%b, want 0", busy_a); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (last_done_cyc - start_cyc !== 13) $display("FAIL stall_latency: got %0d, want 13", last_done_cyc - start_cyc); else n_pass++;
      n_checks++; if (done_cnt_a !== d0 + 1) $display("FAIL stall_done_cnt: got %0d, want 1", done_cnt_a - d0); else n_pass++;
      n_checks++; if (exp_q.size() !== 0) $display("FAIL stall_queue: got %0d left, want 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_start_ignored;
      int d0 = done_cnt_a;
      bit ok;
      send_start(4'd0);
      repeat (3) @(posedge clk);
      #1 start_a = 1'b1;
      @(posedge clk);
      #1 start_a = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      n_checks++; if (done_a !== 1'b1) $display("FAIL ignored_done: got %b, want 1", done_a); else n_pass++;
      // Start presented in the done cycle must be taken.
      repeat_count = 4'd0;
      start_a = 1'b1;
      push_pattern(1);
      @(posedge clk); #1;
      start_cyc = cyc;
      start_a = 1'b0;
      n_checks++; if (data_a !== 3'b001 || valid_a !== 1'b1) $display("FAIL done_cycle_start: got data=%b valid=%b, want 001/1", data_a, valid_a); else n_pass++;
      wait_idle(50, ok);
      n_checks++; if (!ok) $display("FAIL ignored_timeout: got busy=%b, want 0", busy_a); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (last_done_cyc - start_cyc !== 8) $display("FAIL ignored_latency: got %0d, want 8", last_done_cyc - start_cyc); else n_pass++;
      n_checks++; if (done_cnt_a !== d0 + 2) $display("FAIL ignored_done_cnt: got %0d, want 2", done_cnt_a - d0); else n_pass++;
      n_checks++; if (exp_q.size() !== 0) $display("FAIL ignored_queue: got %0d left, want 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_reset_mid;
      int d0 = done_cnt_a;
      bit ok;
      send_start(4'd0);
      repeat (6) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      n_checks++; if (data_a !== 3'b111 || valid_a !== 1'b0) $display("FAIL mid_rst_data: got data=%b valid=%b, want 111/0", data_a, valid_a); else n_pass++;
      n_checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) $display("FAIL mid_rst_busy: got busy=%b done=%b, want 0/0", busy_a, done_a); else n_pass++;
      exp_q.delete();
      @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (done_cnt_a !== d0 || busy_a !== 1'b0) $display("FAIL mid_rst_nodone: got done_cnt=%0d busy=%b, want 0/0", done_cnt_a - d0, busy_a); else n_pass++;
      send_start(4'd0);
      n_checks++; if (data_a !== 3'b001) $display("FAIL mid_rst_restart: got %b, want 001", data_a); else n_pass++;
      wait_idle(50, ok);
      n_checks++; if (!ok) $display("FAIL mid_rst_timeout: got busy=%b, want 0", busy_a); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (done_cnt_a !== d0 + 1) $display("FAIL mid_rst_done_cnt: got %0d, want 1", done_cnt_a - d0); else n_pass++;
      n_checks++; if (exp_q.size() !== 0) $display("FAIL mid_rst_queue: got %0d left, want 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_back_to_back;
      repeat_count = 4'd2;
      start_b = 1'b1;
      @(posedge clk);
      #1 start_b = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         n_checks++; if (valid_b !== 1'b1 || data_b !== pat[i % 8]) $display("FAIL b2b_sym[%0d]: got %b/%b, want %b/1", i, data_b, valid_b, pat[i % 8]); else n_pass++;
      end
      @(negedge clk);
      n_checks++; if (done_b !== 1'b1 || busy_b !== 1'b0 || data_b !== 3'b111) $display("FAIL b2b_done: got done=%b busy=%b data=%b, want 1/0/111", done_b, busy_b, data_b); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_random_ready;
      int d0 = done_cnt_a;
      bit ok = 1'b0;
      send_start(4'($urandom_range(1, 3)));
      for (int i = 0; i < 600; i++) begin
         ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         if (busy_a === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      ready = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (!ok) $display("FAIL rand_timeout: got busy=%b, want 0", busy_a); else n_pass++;
      n_checks++; if (done_cnt_a !== d0 + 1) $display("FAIL rand_done_cnt: got %0d, want 1", done_cnt_a - d0); else n_pass++;
      n_checks++; if (exp_q.size() !== 0) $display("FAIL rand_queue: got %0d left, want 0", exp_q.size()); else n_pass++;
   endtask

`ifdef SEQ_GEN_ABORT_EN
   task automatic test_abort;
      int d0 = done_cnt_a;
      int bad = 0;
      send_start(4'd2);
      repeat (3) @(posedge clk);
      #1;
      abort = 1'b1;
      start_a = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      start_a = 1'b0;
      exp_q.delete();
      @(negedge clk);
      n_checks++; if (valid_a !== 1'b0 || data_a !== 3'b111 || busy_a !== 1'b0 || done_a !== 1'b0) $display("FAIL abort_idle: got valid=%b data=%b busy=%b done=%b, want 0/111/0/0", valid_a, data_a, busy_a, done_a); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (busy_a !== 1'b0) bad++;
      end
      n_checks++; if (bad !== 0) $display("FAIL abort_restart: got %0d busy cycles, want 0", bad); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (done_cnt_a !== d0) $display("FAIL abort_done_cnt: got %0d, want 0", done_cnt_a - d0); else n_pass++;
   endtask
`endif

   initial begin
      pat = '{3'b001, 3'b101, 3'b110, 3'b000, 3'b110, 3'b110, 3'b011, 3'b101};
      reset_n      = 1'b0;
      start_a      = 1'b0;
      start_b      = 1'b0;
      repeat_count = 4'd0;
      ready        = 1'b1;
`ifdef SEQ_GEN_ABORT_EN
      abort        = 1'b0;
`endif
      test_reset();
      test_single();
      test_gap();
      test_stall();
      test_start_ignored();
      test_reset_mid();
      test_back_to_back();
      test_random_ready();
`ifdef SEQ_GEN_ABORT_EN
      test_abort();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
